// File: rtl/alu_decode_stage.sv
// ALU decode stage: turns an RV32I/RV64IM instruction into ALU operands, an operation code
// and CSR immediate, behind a single-entry valid/ready pipeline register with EX/MEM forwarding.
module alu_decode_stage #(
    parameter int XLEN   = 64,
    parameter int VADDR  = 39,
    parameter int FWD_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      inst_i,
    input  logic [VADDR-1:0] pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_fwd_valid_i,
    input  logic [4:0]       ex_fwd_rd_i,
    input  logic [XLEN-1:0]  ex_fwd_data_i,
    input  logic             mem_fwd_valid_i,
    input  logic [4:0]       mem_fwd_rd_i,
    input  logic [XLEN-1:0]  mem_fwd_data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  alu_op_a_o,
    output logic [XLEN-1:0]  alu_op_b_o,
    output logic [5:0]       alu_operation_o,
    output logic             alu_uses_rs1_o,
    output logic             alu_uses_rs2_o,
    output logic [XLEN-1:0]  csr_imm_o,
    output logic [4:0]       rd_o,
    output logic             illegal_o
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [5:0] ALU_OP_ADD  = 6'b000000;
    localparam logic [5:0] ALU_OP_PASS = 6'b111111;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic       load;

    assign opcode  = inst_i[6:0];
    assign func3   = inst_i[14:12];
    assign rs1_idx = inst_i[19:15];
    assign rs2_idx = inst_i[24:20];
    assign ready_o = ~valid_o | ready_i;
    assign load    = valid_i & ready_o;

    // Immediates, sign-extended through signed intermediates
    logic signed [11:0] i_imm12;
    logic signed [11:0] s_imm12;
    logic signed [12:0] b_imm13;
    logic signed [20:0] j_imm21;
    logic signed [31:0] u_imm32;
    logic [XLEN-1:0]    i_imm;
    logic [XLEN-1:0]    s_imm;
    logic [XLEN-1:0]    b_imm;
    logic [XLEN-1:0]    j_imm;
    logic [XLEN-1:0]    u_imm;
    logic [XLEN-1:0]    pc_ext;
    logic [XLEN-1:0]    csr_imm;

    assign i_imm12 = inst_i[31:20];
    assign s_imm12 = {inst_i[31:25], inst_i[11:7]};
    assign b_imm13 = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign j_imm21 = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign u_imm32 = {inst_i[31:12], 12'b0};
    assign i_imm   = XLEN'(i_imm12);
    assign s_imm   = XLEN'(s_imm12);
    assign b_imm   = XLEN'(b_imm13);
    assign j_imm   = XLEN'(j_imm21);
    assign u_imm   = XLEN'(u_imm32);
    assign pc_ext  = XLEN'(pc_i);
    assign csr_imm = XLEN'(rs1_idx);

    // EX beats MEM beats register file; x0 is never forwarded
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = rs1_data_i;
        rs2_val = rs2_data_i;
        if (FWD_EN != 0) begin
            if (rs1_idx != 5'd0) begin
                if (ex_fwd_valid_i && ex_fwd_rd_i == rs1_idx) begin
                    rs1_val = ex_fwd_data_i;
                end else if (mem_fwd_valid_i && mem_fwd_rd_i == rs1_idx) begin
                    rs1_val = mem_fwd_data_i;
                end
            end
            if (rs2_idx != 5'd0) begin
                if (ex_fwd_valid_i && ex_fwd_rd_i == rs2_idx) begin
                    rs2_val = ex_fwd_data_i;
                end else if (mem_fwd_valid_i && mem_fwd_rd_i == rs2_idx) begin
                    rs2_val = mem_fwd_data_i;
                end
            end
        end
    end

    logic       op_imm;
    logic       is_shift;
    logic       non_shift_imm;
    logic       csr_imm_op;
    logic [5:0] arith_op;

    assign op_imm        = (opcode == OPC_OP_IMM) || (opcode == OPC_OP_IMM_W);
    assign is_shift      = (func3 == 3'b001) || (func3 == 3'b101);
    assign non_shift_imm = op_imm & ~is_shift;
    assign csr_imm_op    = (opcode == OPC_SYSTEM) && func3[2] && (func3[1:0] != 2'b00);
    assign arith_op      = {inst_i[30] & ~non_shift_imm, inst_i[25] & ~op_imm, func3, opcode[3]};

    logic [XLEN-1:0] op_a_d;
    logic [XLEN-1:0] op_b_d;
    logic [5:0]      operation_d;
    logic            illegal_d;
    logic            uses_rs1_d;
    logic            uses_rs2_d;

    assign uses_rs2_d = (opcode == OPC_OP) || (opcode == OPC_OP_W);
    assign uses_rs1_d = csr_imm_op ||
                        !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                          (opcode == OPC_JAL) || (opcode == OPC_BRANCH));

    // Illegal encodings fall back to ADD with the forwarded register operands
    always_comb begin
        op_a_d      = rs1_val;
        op_b_d      = rs2_val;
        operation_d = ALU_OP_ADD;
        illegal_d   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                op_a_d      = u_imm;
                operation_d = ALU_OP_PASS;
            end
            OPC_AUIPC: begin
                op_a_d = u_imm;
                op_b_d = pc_ext;
            end
            OPC_JAL: begin
                op_a_d = j_imm;
                op_b_d = pc_ext;
            end
            OPC_BRANCH: begin
                op_a_d = b_imm;
                op_b_d = pc_ext;
            end
            OPC_JALR, OPC_LOAD: op_b_d = i_imm;
            OPC_STORE:          op_b_d = s_imm;
            OPC_OP_IMM: begin
                if (XLEN == 32 && is_shift && inst_i[25]) begin
                    illegal_d = 1'b1;
                end else begin
                    op_b_d      = i_imm;
                    operation_d = arith_op;
                end
            end
            OPC_OP_IMM_W: begin
                if (XLEN == 32) begin
                    illegal_d = 1'b1;
                end else begin
                    op_b_d      = i_imm;
                    operation_d = arith_op;
                end
            end
            OPC_OP: operation_d = arith_op;
            OPC_OP_W: begin
                if (XLEN == 32) begin
                    illegal_d = 1'b1;
                end else begin
                    operation_d = arith_op;
                end
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                if (csr_imm_op) begin
                    op_a_d = csr_imm;
                end
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Flush wins over load; data registers only move on an accepted, unflushed load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o         <= 1'b0;
            alu_op_a_o      <= '0;
            alu_op_b_o      <= '0;
            alu_operation_o <= '0;
            alu_uses_rs1_o  <= 1'b0;
            alu_uses_rs2_o  <= 1'b0;
            csr_imm_o       <= '0;
            rd_o            <= '0;
            illegal_o       <= 1'b0;
        end else begin
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (load) begin
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
            if (load && !flush_i) begin
                alu_op_a_o      <= op_a_d;
                alu_op_b_o      <= op_b_d;
                alu_operation_o <= operation_d;
                alu_uses_rs1_o  <= uses_rs1_d;
                alu_uses_rs2_o  <= uses_rs2_d;
                csr_imm_o       <= csr_imm;
                rd_o            <= inst_i[11:7];
                illegal_o       <= illegal_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: a 64-bit and a 32-bit instance, directed vectors
// with hand-computed expectations queued at issue and checked when each entry transfers.
module tb_alu_decode_stage;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  op;
        logic        u1;
        logic        u2;
        logic [63:0] csr;
        logic [4:0]  rd;
        logic        ill;
        logic        chk_ab;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        v64 = 1'b0;
    logic        v32 = 1'b0;
    logic        rdy64 = 1'b1;
    logic [31:0] inst = '0;
    logic [38:0] pc = 39'h1000;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic        exv = 1'b0;
    logic [4:0]  exrd = '0;
    logic [63:0] exd = '0;
    logic        memv = 1'b0;
    logic [4:0]  memrd = '0;
    logic [63:0] memd = '0;

    logic        ro64, vo64, u1_64, u2_64, ill64;
    logic [63:0] a64, b64, csr64;
    logic [5:0]  op64;
    logic [4:0]  rd64;
    logic        ro32, vo32, u1_32, u2_32, ill32;
    logic [31:0] a32, b32, csr32;
    logic [5:0]  op32;
    logic [4:0]  rd32;

    int total = 0;
    int bad = 0;
    exp_t q64[$];
    exp_t q32[$];
    exp_t e64, e32;

    always #5 clk = ~clk;

    alu_decode_stage #(.XLEN(64), .VADDR(39), .FWD_EN(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v64), .ready_o(ro64),
        .inst_i(inst), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .ex_fwd_valid_i(exv), .ex_fwd_rd_i(exrd), .ex_fwd_data_i(exd),
        .mem_fwd_valid_i(memv), .mem_fwd_rd_i(memrd), .mem_fwd_data_i(memd),
        .valid_o(vo64), .ready_i(rdy64), .alu_op_a_o(a64), .alu_op_b_o(b64),
        .alu_operation_o(op64), .alu_uses_rs1_o(u1_64), .alu_uses_rs2_o(u2_64),
        .csr_imm_o(csr64), .rd_o(rd64), .illegal_o(ill64)
    );

    alu_decode_stage #(.XLEN(32), .VADDR(32), .FWD_EN(1)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .valid_i(v32), .ready_o(ro32),
        .inst_i(inst), .pc_i(pc[31:0]), .rs1_data_i(rs1[31:0]), .rs2_data_i(rs2[31:0]),
        .ex_fwd_valid_i(1'b0), .ex_fwd_rd_i(5'd0), .ex_fwd_data_i(32'd0),
        .mem_fwd_valid_i(1'b0), .mem_fwd_rd_i(5'd0), .mem_fwd_data_i(32'd0),
        .valid_o(vo32), .ready_i(1'b1), .alu_op_a_o(a32), .alu_op_b_o(b32),
        .alu_operation_o(op32), .alu_uses_rs1_o(u1_32), .alu_uses_rs2_o(u2_32),
        .csr_imm_o(csr32), .rd_o(rd32), .illegal_o(ill32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] op, input logic u1, input logic u2,
                       input logic [63:0] csr, input logic [4:0] rd, input logic ill);
        if (e.chk_ab) begin
            chk({tag, "_op_a"}, a, e.a);
            chk({tag, "_op_b"}, b, e.b);
            chk({tag, "_uses_rs1"}, 64'(u1), 64'(e.u1));
            chk({tag, "_uses_rs2"}, 64'(u2), 64'(e.u2));
        end
        chk({tag, "_operation"}, 64'(op), 64'(e.op));
        chk({tag, "_csr_imm"}, csr, e.csr);
        chk({tag, "_rd"}, 64'(rd), 64'(e.rd));
        chk({tag, "_illegal"}, 64'(ill), 64'(e.ill));
    endtask

    function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input logic [5:0] op,
                                input logic u1, input logic u2, input logic [63:0] csr,
                                input logic [4:0] rd, input logic ill, input logic chk_ab);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.u1 = u1; e.u2 = u2;
        e.csr = csr; e.rd = rd; e.ill = ill; e.chk_ab = chk_ab;
        return e;
    endfunction

    // Monitors: an entry transfers on the next rising edge when valid_o & ready_i
    always @(negedge clk) begin
        if (!rst && vo64 && rdy64) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL dut64_unexpected_entry: got valid_o=1, expected no entry");
            end else begin
                e64 = q64.pop_front();
                cmp("dut64", e64, a64, b64, op64, u1_64, u2_64, csr64, rd64, ill64);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vo32) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL dut32_unexpected_entry: got valid_o=1, expected no entry");
            end else begin
                e32 = q32.pop_front();
                cmp("dut32", e32, {32'd0, a32}, {32'd0, b32}, op32, u1_32, u2_32,
                    {32'd0, csr32}, rd32, ill32);
            end
        end
    end

    task automatic send(input bit sel32, input logic [31:0] i, input logic [63:0] r1,
                        input logic [63:0] r2, input exp_t e);
        inst = i; rs1 = r1; rs2 = r2;
        if (sel32) begin
            v32 = 1'b1; q32.push_back(e);
        end else begin
            v64 = 1'b1; q64.push_back(e);
        end
        @(negedge clk);
        chk(sel32 ? "dut32_ready_accept" : "dut64_ready_accept", 64'(sel32 ? ro32 : ro64), 64'd1);
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
    endtask

    task automatic set_fwd(input logic ev, input logic [4:0] er, input logic [63:0] ed,
                           input logic mv, input logic [4:0] mr, input logic [63:0] md);
        exv = ev; exrd = er; exd = ed; memv = mv; memrd = mr; memd = md;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_valid_o", 64'(vo64), 64'd0);
        chk("rst_ready_o", 64'(ro64), 64'd1);
        chk("rst_op_a", a64, 64'd0);
        chk("rst_operation", 64'(op64), 64'd0);
        chk("rst_illegal", 64'(ill64), 64'd0);
        chk("rst_valid_o_32", 64'(vo32), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back directed vectors on the 64-bit instance
        send(0, 32'hFFF08293, 64'h10, 64'h22, mk(64'h10, ONES, 6'h00, 1, 0, 64'h1, 5'd5, 0, 1));
        set_fwd(1, 5'd1, 64'hAA, 1, 5'd2, 64'hCC);
        send(0, 32'h002081B3, 64'h11, 64'h22, mk(64'hAA, 64'hCC, 6'h00, 1, 1, 64'h1, 5'd3, 0, 1));
        set_fwd(1, 5'd1, 64'hAA, 1, 5'd1, 64'hBB);
        send(0, 32'h002081B3, 64'h11, 64'h22, mk(64'hAA, 64'h22, 6'h00, 1, 1, 64'h1, 5'd3, 0, 1));
        set_fwd(0, 5'd1, 64'hAA, 1, 5'd1, 64'hBB);
        send(0, 32'h002081B3, 64'h11, 64'h22, mk(64'hBB, 64'h22, 6'h00, 1, 1, 64'h1, 5'd3, 0, 1));
        set_fwd(1, 5'd0, 64'hAA, 1, 5'd0, 64'hBB);
        send(0, 32'h000001B3, 64'h11, 64'h22, mk(64'h11, 64'h22, 6'h00, 1, 1, 64'h0, 5'd3, 0, 1));
        set_fwd(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        send(0, 32'h402081B3, 64'h11, 64'h22, mk(64'h11, 64'h22, 6'h20, 1, 1, 64'h1, 5'd3, 0, 1));
        send(0, 32'h4030D293, 64'h11, 64'h22, mk(64'h11, 64'h403, 6'h2A, 1, 0, 64'h1, 5'd5, 0, 1));
        send(0, 32'h022081B3, 64'h11, 64'h22, mk(64'h11, 64'h22, 6'h10, 1, 1, 64'h1, 5'd3, 0, 1));
        send(0, 32'h002081BB, 64'h11, 64'h22, mk(64'h11, 64'h22, 6'h01, 1, 1, 64'h1, 5'd3, 0, 1));
        send(0, 32'h800002B7, 64'h11, 64'h22,
             mk(64'hFFFF_FFFF_8000_0000, 64'h22, 6'h3F, 0, 0, 64'h0, 5'd5, 0, 1));
        pc = 39'h7F_FFFF_F000;
        send(0, 32'h00000297, 64'h11, 64'h22,
             mk(64'h0, 64'h0000_007F_FFFF_F000, 6'h00, 0, 0, 64'h0, 5'd5, 0, 1));
        pc = 39'h1000;
        send(0, 32'hFFDFF0EF, 64'h11, 64'h22, mk(ONES - 64'd3, 64'h1000, 6'h00, 0, 0, 64'h1F, 5'd1, 0, 1));
        send(0, 32'h300FD2F3, 64'h11, 64'h22, mk(64'h1F, 64'h22, 6'h00, 1, 0, 64'h1F, 5'd5, 0, 1));
        send(0, 32'h0020A423, 64'h11, 64'h22, mk(64'h11, 64'h8, 6'h00, 1, 0, 64'h1, 5'd8, 0, 1));
        send(0, 32'h0000007F, 64'h11, 64'h22, mk(64'h0, 64'h0, 6'h00, 0, 0, 64'h0, 5'd0, 1, 0));

        // Stall: held SUB must survive changing inst and forwarding, then MUL follows once
        inst = 32'h402081B3; rs1 = 64'h11; rs2 = 64'h22; v64 = 1'b1;
        q64.push_back(mk(64'h11, 64'h22, 6'h20, 1, 1, 64'h1, 5'd3, 0, 1));
        @(posedge clk); #1;
        rdy64 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inst = (k == 0) ? 32'h002081BB : ((k == 1) ? 32'h4030D293 : 32'hFFDFF0EF);
            set_fwd(1, 5'd1, 64'h55 + 64'(k), 1, 5'd2, 64'h66);
            @(negedge clk);
            chk("stall_ready_o", 64'(ro64), 64'd0);
            chk("stall_valid_o", 64'(vo64), 64'd1);
            @(posedge clk); #1;
        end
        set_fwd(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        inst = 32'h022081B3; rdy64 = 1'b1;
        q64.push_back(mk(64'h11, 64'h22, 6'h10, 1, 1, 64'h1, 5'd3, 0, 1));
        @(negedge clk);
        chk("release_ready_o", 64'(ro64), 64'd1);
        @(posedge clk); #1;
        v64 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("release_no_dup_valid_o", 64'(vo64), 64'd0);

        // Flush coincident with an incoming instruction
        @(posedge clk); #1;
        inst = 32'hFFF08293; v64 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_incoming_valid_o", 64'(vo64), 64'd0);

        // Flush of a held entry
        @(posedge clk); #1;
        inst = 32'h402081B3; v64 = 1'b1;
        q64.push_back(mk(64'h11, 64'h22, 6'h20, 1, 1, 64'h1, 5'd3, 0, 1));
        @(posedge clk); #1;
        v64 = 1'b0; rdy64 = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(q64.pop_back());
        @(negedge clk);
        chk("flush_held_valid_o", 64'(vo64), 64'd0);
        rdy64 = 1'b1;

        // Reset while stalled
        @(posedge clk); #1;
        inst = 32'h002081B3; v64 = 1'b1;
        q64.push_back(mk(64'h11, 64'h22, 6'h00, 1, 1, 64'h1, 5'd3, 0, 1));
        @(posedge clk); #1;
        v64 = 1'b0; rdy64 = 1'b0;
        @(negedge clk);
        chk("prerst_valid_o", 64'(vo64), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid_o", 64'(vo64), 64'd0);
        chk("midrst_ready_o", 64'(ro64), 64'd1);
        chk("midrst_op_a", a64, 64'd0);
        q64.delete();
        @(posedge clk); #1;
        rst = 1'b0; rdy64 = 1'b1;

        // 32-bit instance
        send(1, 32'h800002B7, 64'h11, 64'h22, mk(64'h8000_0000, 64'h22, 6'h3F, 0, 0, 64'h0, 5'd5, 0, 1));
        send(1, 32'h002081BB, 64'h11, 64'h22, mk(64'h0, 64'h0, 6'h00, 0, 0, 64'h1, 5'd3, 1, 0));
        send(1, 32'h02009293, 64'h11, 64'h22, mk(64'h0, 64'h0, 6'h00, 0, 0, 64'h1, 5'd5, 1, 0));
        send(1, 32'h00309293, 64'h11, 64'h22, mk(64'h11, 64'h3, 6'h02, 1, 0, 64'h1, 5'd5, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("q64_drained", 64'(q64.size()), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
